// File: rtl/serial_mag_comp.sv
// ----------------------------------------------------------------------------
// serial_mag_comp
//
// Purpose:
//   Sequential unsigned magnitude comparator. Operands are latched on an
//   accepted start and compared MSB-first, one 2-bit slice per clock. The
//   compare stops at the first unequal slice, or after the last slice when
//   all slices are equal, and reports gt/lt/eq with a one-cycle done pulse.
//   WIDTH must be even and at least 2.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   start_i  - compare request, only looked at while idle
//   a_i      - operand A (unsigned), captured with an accepted start
//   b_i      - operand B (unsigned), captured with an accepted start
//   busy_o   - high while a compare is running or its result is presented
//   done_o   - one-cycle pulse marking a fresh result
//   gt_o     - A > B for the last completed compare
//   lt_o     - A < B for the last completed compare
//   eq_o     - A == B for the last completed compare
// ----------------------------------------------------------------------------
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             gt_q,    gt_d;
  logic             lt_q,    lt_d;
  logic             eq_q,    eq_d;

  // Top slice of each shift register: the slice under evaluation this cycle.
  logic [1:0] slice_a;
  logic [1:0] slice_b;
  logic       slice_gt;
  logic       slice_lt;

  assign slice_a = a_sh_q[WIDTH-1 -: 2];
  assign slice_b = b_sh_q[WIDTH-1 -: 2];

  // 2-bit magnitude slice: equality is implied when neither gt nor lt.
  assign slice_gt = (slice_a[1] & ~slice_b[1]) |
                    ((slice_a[1] ~^ slice_b[1]) & slice_a[0] & ~slice_b[0]);
  assign slice_lt = (~slice_a[1] & slice_b[1]) |
                    ((slice_a[1] ~^ slice_b[1]) & ~slice_a[0] & slice_b[0]);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          cnt_d   = '0;
          state_d = S_CMP;
        end
      end

      S_CMP: begin
        a_sh_d = a_sh_q << 2;
        b_sh_d = b_sh_q << 2;
        if (slice_gt || slice_lt) begin
          // First differing slice decides the whole compare.
          gt_d    = slice_gt;
          lt_d    = slice_lt;
          eq_d    = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == LAST_SLICE) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          // Only advance while slices remain, so the counter never wraps.
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others. The operand shift registers are
  // ordinary flops and are cleared with everything else on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign gt_o   = gt_q;
  assign lt_o   = lt_q;
  assign eq_o   = eq_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// ----------------------------------------------------------------------------
// tb_serial_mag_comp
//
// Self-checking bench for serial_mag_comp (WIDTH = 8). Stimulus pushes one
// scoreboard entry per accepted start (operands and acceptance time); a
// negedge monitor pops an entry on every done pulse and compares result and
// latency against a plain-arithmetic reference model. Between done pulses the
// monitor checks that gt/lt/eq hold the last expected result.
// ----------------------------------------------------------------------------
module tb_serial_mag_comp;

  localparam int  W = 8;
  localparam time P = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic         gt_o;
  logic         lt_o;
  logic         eq_o;

  always #(P/2) clk = ~clk;

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .gt_o   (gt_o),
    .lt_o   (lt_o),
    .eq_o   (eq_o)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    time          t_acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned compare, and the 1-based index of the first
  // differing 2-bit slice from the MSB (W/2 when the operands are equal).
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [2:0] res, output int k);
    bit found;
    res   = {a > b, a < b, a == b};
    k     = W / 2;
    found = 1'b0;
    for (int i = 1; i <= W / 2; i++) begin
      if (!found && (((a >> (W - 2 * i)) & 8'd3) != ((b >> (W - 2 * i)) & 8'd3))) begin
        k     = i;
        found = 1'b1;
      end
    end
  endfunction

  // Monitor: decoupled from stimulus, driven only by the DUT's done pulse.
  logic [2:0] held = 3'b000;

  always @(negedge clk) begin : mon
    exp_t       e;
    logic [2:0] r;
    int         k;
    if (!rst_n) begin
      held = 3'b000;
    end else if (done_o) begin
      if (sb.size() == 0) begin
        check("done_without_request", {63'd0, done_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        ref_model(e.a, e.b, r, k);
        check("result_gt_lt_eq", {61'd0, gt_o, lt_o, eq_o}, {61'd0, r});
        check("done_time", $time, e.t_acc + k * P + P / 2);
        held = r;
      end
    end else begin
      check("result_hold", {61'd0, gt_o, lt_o, eq_o}, {61'd0, held});
    end
  end

  // Returns at a falling edge where the DUT is idle (bounded wait).
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {63'd0, busy_o}, 64'd0);
  endtask

  // Issues one compare. When scramble is set, operands and start are
  // randomised right after acceptance to prove they are ignored while busy.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track, input bit scramble);
    wait_idle();
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    @(posedge clk);
    if (track) sb.push_back('{a, b, $time});
    #1;
    if (scramble) begin
      start_i = 1'($urandom);
      a_i     = W'($urandom);
      b_i     = W'($urandom);
    end else begin
      start_i = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    rst_n   = 1'b0;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    #12;
    check("reset_outputs", {59'd0, busy_o, done_o, gt_o, lt_o, eq_o}, 64'd0);
    #5 rst_n = 1'b1;

    // Directed vectors, the first one on the first edge out of reset.
    issue(8'hA5, 8'hA5, 1'b1, 1'b0);
    issue(8'h80, 8'h7F, 1'b1, 1'b1);
    issue(8'h12, 8'h13, 1'b1, 1'b1);
    issue(8'h00, 8'h00, 1'b1, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b1);
    issue(8'hFF, 8'h00, 1'b1, 1'b0);
    issue(8'h00, 8'hFF, 1'b1, 1'b1);
    issue(8'h01, 8'h00, 1'b1, 1'b0);
    issue(8'h00, 8'h01, 1'b1, 1'b1);

    // start held high across two compares; operand changes while busy.
    wait_idle();
    start_i = 1'b1;
    a_i     = 8'h40;
    b_i     = 8'h10;
    @(posedge clk);
    sb.push_back('{8'h40, 8'h10, $time});
    #1;
    a_i = 8'h00;
    b_i = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("idle_gap_busy", {63'd0, busy_o}, 64'd0);
    @(posedge clk);
    sb.push_back('{8'h00, 8'hFF, $time});
    #1;
    start_i = 1'b0;
    a_i     = 8'hFF;
    b_i     = 8'h00;

    // Reset in the middle of a compare aborts it.
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", {59'd0, busy_o, done_o, gt_o, lt_o, eq_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_stays_idle", {63'd0, busy_o}, 64'd0);
    end
    issue(8'h01, 8'h01, 1'b1, 1'b0);
    issue(8'hC3, 8'hC2, 1'b1, 1'b1);

    // Random sweep biased toward long shared prefixes.
    for (int i = 0; i < 4000; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      endcase
      issue(ra, rb, 1'b1, 1'b1);
    end

    wait_idle();
    start_i = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
